// File: rtl/collision_detector_if.sv
// Obstacle select bus: the detector drives the index, an external mux returns that obstacle's box.
// Latency: combinational; the box must be valid in the same cycle as obs_sel.
// Backpressure: none; the detector reads one box per cycle while scanning.
interface collision_detector_if #(
    parameter int IDX_W = 2
);
    logic [IDX_W-1:0] obs_sel;
    logic [11:0]      obs_x1;
    logic [11:0]      obs_x2;
    logic [11:0]      obs_y1;
    logic [11:0]      obs_y2;

    // Detector side: drives the select, reads the chosen box
    modport master (
        output obs_sel,
        input  obs_x1,
        input  obs_x2,
        input  obs_y1,
        input  obs_y2
    );

    // Mux side: reads the select, returns the chosen box
    modport slave (
        input  obs_sel,
        output obs_x1,
        output obs_x2,
        output obs_y1,
        output obs_y2
    );
endinterface

// File: rtl/collision_detector.sv
// Per-frame dino/obstacle overlap scan with consecutive-frame hit filtering and sticky game-over.
// Latency: strobe at T, scan T+1..T+N_OBS, decide at T+N_OBS+1, results visible at T+N_OBS+2.
// Backpressure: strobes arriving while busy or after game-over are dropped, not queued.
module collision_detector #(
    parameter int N_OBS      = 3,
    parameter int IDX_W      = 2,
    parameter int HIT_FRAMES = 2,
    parameter int MARGIN     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ani_stb,
    input  logic                 i_animate,
    input  logic                 i_grace,
    input  logic [11:0]          i_dino_x1,
    input  logic [11:0]          i_dino_x2,
    input  logic [11:0]          i_dino_y1,
    input  logic [11:0]          i_dino_y2,
    collision_detector_if.master obs,
    output logic                 o_busy,
    output logic                 o_hit,
    output logic                 o_game_over,
    output logic [IDX_W-1:0]     o_hit_idx
);

    localparam int CNT_W = (HIT_FRAMES < 1) ? 1 : $clog2(HIT_FRAMES + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_OBS - 1);
    localparam logic [CNT_W:0]     HIT_LIMIT  = (CNT_W + 1)'(HIT_FRAMES);
    // One bit wider than the 13-bit signed compare so dino +/- MARGIN cannot wrap.
    localparam logic signed [13:0] MARGIN_S   = 14'(MARGIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [11:0]      dx1_q, dx1_d;
    logic [11:0]      dx2_q, dx2_d;
    logic [11:0]      dy1_q, dy1_d;
    logic [11:0]      dy2_q, dy2_d;
    logic             frame_hit_q, frame_hit_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic             game_over_q, game_over_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;

    logic signed [13:0] ox1_s, ox2_s, oy1_s, oy2_s;
    logic signed [13:0] dx1_s, dx2_s, dy1_s, dy2_s;
    logic               box_overlap;
    logic [CNT_W:0]     cnt_inc;

    // Overlap of the currently selected obstacle against the shrunken dino snapshot
    always_comb begin
        ox1_s = {{2{obs.obs_x1[11]}}, obs.obs_x1};
        ox2_s = {{2{obs.obs_x2[11]}}, obs.obs_x2};
        oy1_s = {{2{obs.obs_y1[11]}}, obs.obs_y1};
        oy2_s = {{2{obs.obs_y2[11]}}, obs.obs_y2};
        dx1_s = {2'b00, dx1_q};
        dx2_s = {2'b00, dx2_q};
        dy1_s = {2'b00, dy1_q};
        dy2_s = {2'b00, dy2_q};
        // Strict compares: boxes that only touch after shrinking do not collide.
        box_overlap = (ox1_s < (dx2_s - MARGIN_S)) &&
                      (ox2_s > (dx1_s + MARGIN_S)) &&
                      (oy1_s < (dy2_s - MARGIN_S)) &&
                      (oy2_s > (dy1_s + MARGIN_S));
    end

    // FSM next state, scan bookkeeping and per-frame hit decision
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        dx1_d       = dx1_q;
        dx2_d       = dx2_q;
        dy1_d       = dy1_q;
        dy2_d       = dy2_q;
        frame_hit_d = frame_hit_q;
        first_idx_d = first_idx_q;
        cnt_d       = cnt_q;
        hit_d       = 1'b0;
        game_over_d = game_over_q;
        hit_idx_d   = hit_idx_q;
        cnt_inc     = {1'b0, cnt_q} + (CNT_W + 1)'(1);

        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (i_ani_stb && i_animate && !game_over_q) begin
                    // Snapshot the dino so it cannot move underneath the scan.
                    dx1_d       = i_dino_x1;
                    dx2_d       = i_dino_x2;
                    dy1_d       = i_dino_y1;
                    dy2_d       = i_dino_y2;
                    frame_hit_d = 1'b0;
                    first_idx_d = '0;
                    state_d     = ST_SCAN;
                end
            end

            ST_SCAN: begin
                // Only the first overlapping index is kept, i.e. the lowest one.
                if (box_overlap && !frame_hit_q) begin
                    frame_hit_d = 1'b1;
                    first_idx_d = sel_q;
                end
                if (sel_q == LAST_IDX) begin
                    sel_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    sel_d = sel_q + IDX_W'(1);
                end
            end

            ST_DONE: begin
                if (frame_hit_q && !i_grace) begin
                    if (cnt_inc >= HIT_LIMIT) begin
                        cnt_d       = CNT_W'(HIT_FRAMES);
                        hit_d       = 1'b1;
                        game_over_d = 1'b1;
                        hit_idx_d   = first_idx_q;
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end else begin
                    // A clear frame or a grace frame breaks the consecutive run.
                    cnt_d = '0;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // State and result registers; reset also aborts any scan in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            dx1_q       <= '0;
            dx2_q       <= '0;
            dy1_q       <= '0;
            dy2_q       <= '0;
            frame_hit_q <= 1'b0;
            first_idx_q <= '0;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
            hit_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            dx1_q       <= dx1_d;
            dx2_q       <= dx2_d;
            dy1_q       <= dy1_d;
            dy2_q       <= dy2_d;
            frame_hit_q <= frame_hit_d;
            first_idx_q <= first_idx_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            game_over_q <= game_over_d;
            hit_idx_q   <= hit_idx_d;
        end
    end

    assign obs.obs_sel  = sel_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_hit        = hit_q;
    assign o_game_over  = game_over_q;
    assign o_hit_idx    = hit_idx_q;

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: per-frame expectations queued at strobe, checked at result cycle.
// Latency: drives and samples on the falling edge; results checked at T+5 for N_OBS=3.
// Backpressure: exercises dropped strobes (busy, animate low, game-over).
module tb_collision_detector;

    localparam int N_OBS  = 3;
    localparam int IDX_W  = 2;
    localparam int HF     = 2;
    localparam int MARGIN = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             stb;
    logic             animate;
    logic             grace;
    logic [11:0]      dx1, dx2, dy1, dy2;
    logic             busy;
    logic             hit;
    logic             go;
    logic [IDX_W-1:0] hit_idx;

    always #5 clk = ~clk;

    collision_detector_if #(.IDX_W(IDX_W)) obs_bus ();

    // Obstacle boxes as signed ints; index 3 is never selected but kept far away
    int ox1[4], ox2[4], oy1[4], oy2[4];
    int ddx1, ddx2, ddy1, ddy2;

    // External combinational mux
    always_comb begin
        obs_bus.obs_x1 = 12'(ox1[obs_bus.obs_sel]);
        obs_bus.obs_x2 = 12'(ox2[obs_bus.obs_sel]);
        obs_bus.obs_y1 = 12'(oy1[obs_bus.obs_sel]);
        obs_bus.obs_y2 = 12'(oy2[obs_bus.obs_sel]);
    end

    collision_detector #(
        .N_OBS(N_OBS), .IDX_W(IDX_W), .HIT_FRAMES(HF), .MARGIN(MARGIN)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(animate), .i_grace(grace),
        .i_dino_x1(dx1), .i_dino_x2(dx2), .i_dino_y1(dy1), .i_dino_y2(dy2),
        .obs(obs_bus),
        .o_busy(busy), .o_hit(hit), .o_game_over(go), .o_hit_idx(hit_idx)
    );

    typedef struct {
        bit hit;
        bit go;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mcnt  = 0;
    bit   mgo   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ov(input int i);
        return (ox1[i] < ddx2 - MARGIN) && (ox2[i] > ddx1 + MARGIN) &&
               (oy1[i] < ddy2 - MARGIN) && (oy2[i] > ddy1 + MARGIN);
    endfunction

    task automatic set_dino(input int x1, input int x2, input int y1, input int y2);
        ddx1 = x1; ddx2 = x2; ddy1 = y1; ddy2 = y2;
        dx1 = 12'(x1); dx2 = 12'(x2); dy1 = 12'(y1); dy2 = 12'(y2);
    endtask

    task automatic set_obs(input int i, input int x1, input int x2, input int y1, input int y2);
        ox1[i] = x1; ox2[i] = x2; oy1[i] = y1; oy2[i] = y2;
    endtask

    task automatic all_far();
        for (int i = 0; i < 4; i++) set_obs(i, 1000 + 200 * i, 1100 + 200 * i, 1000, 1100);
    endtask

    // Model of one scanned frame; queues the result the DUT must show
    task automatic model_push(input bit grace_in);
        exp_t e;
        bit   fh = 1'b0;
        int   idx = 0;
        for (int i = N_OBS - 1; i >= 0; i--) begin
            if (ov(i)) begin
                fh  = 1'b1;
                idx = i;
            end
        end
        e.hit = 1'b0;
        e.idx = idx;
        if (fh && !grace_in) begin
            mcnt = (mcnt + 1 > HF) ? HF : mcnt + 1;
            if (mcnt >= HF) begin
                e.hit = 1'b1;
                mgo   = 1'b1;
            end
        end else begin
            mcnt = 0;
        end
        e.go = mgo;
        sb.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_hit"}, hit, 1'b0);
        check_eq({tag, "_go"}, go, 1'b0);
        check_eq({tag, "_idx"}, hit_idx, '0);
        check_eq({tag, "_sel"}, obs_bus.obs_sel, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        mcnt = 0;
        mgo  = 1'b0;
        check_idle_outputs("reset");
    endtask

    // One strobe; optionally a second strobe mid-scan that must be dropped
    task automatic run_frame(input string tag, input bit grace_in, input bit mid_stb);
        exp_t e;
        bit   exp_scan;
        @(negedge clk);
        stb      = 1'b1;
        animate  = 1'b1;
        grace    = grace_in;
        exp_scan = !mgo;
        if (exp_scan) model_push(grace_in);
        @(negedge clk);
        stb = 1'b0;
        if (exp_scan) begin
            for (int i = 0; i < N_OBS; i++) begin
                check_eq({tag, "_scan_busy"}, busy, 1'b1);
                check_eq({tag, "_scan_sel"}, obs_bus.obs_sel, i);
                stb = (i == 0) && mid_stb;
                @(negedge clk);
            end
            stb = 1'b0;
            check_eq({tag, "_done_busy"}, busy, 1'b1);
            check_eq({tag, "_done_hit"}, hit, 1'b0);
            @(negedge clk);
            if (sb.size() == 0) begin
                check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq({tag, "_hit"}, hit, e.hit);
                check_eq({tag, "_go"}, go, e.go);
                if (e.hit) check_eq({tag, "_idx"}, hit_idx, e.idx);
            end
            check_eq({tag, "_res_busy"}, busy, 1'b0);
            @(negedge clk);
            check_eq({tag, "_hit_drop"}, hit, 1'b0);
            check_eq({tag, "_after_busy"}, busy, 1'b0);
        end else begin
            for (int i = 0; i < N_OBS + 2; i++) begin
                check_eq({tag, "_noscan_busy"}, busy, 1'b0);
                check_eq({tag, "_noscan_sel"}, obs_bus.obs_sel, '0);
                check_eq({tag, "_noscan_go"}, go, 1'b1);
                @(negedge clk);
            end
        end
        grace = 1'b0;
    endtask

    task automatic strobe_no_animate();
        @(negedge clk);
        stb     = 1'b1;
        animate = 1'b0;
        @(negedge clk);
        stb     = 1'b0;
        animate = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("anim_low_busy", busy, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic reset_mid_scan();
        @(negedge clk);
        stb     = 1'b1;
        animate = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        check_eq("rstscan_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        mcnt = 0;
        mgo  = 1'b0;
        check_idle_outputs("rstscan");
    endtask

    initial begin
        rst     = 1'b1;
        stb     = 1'b0;
        animate = 1'b0;
        grace   = 1'b0;
        set_dino(100, 150, 200, 250);
        all_far();
        do_reset();

        // 1: disjoint frame
        run_frame("t1", 1'b0, 1'b0);

        // 2: two consecutive overlapping frames, hit on obstacle 1
        set_obs(1, 140, 170, 230, 260);
        run_frame("t2a", 1'b0, 1'b0);
        run_frame("t2b", 1'b0, 1'b0);
        run_frame("t2_go", 1'b0, 1'b0);
        do_reset();

        // 3: a disjoint frame restarts the count
        run_frame("t3a", 1'b0, 1'b0);
        all_far();
        run_frame("t3b", 1'b0, 1'b0);
        set_obs(1, 140, 170, 230, 260);
        run_frame("t3c", 1'b0, 1'b0);
        run_frame("t3d", 1'b0, 1'b0);
        do_reset();

        // 4: margin edge; lowest overlapping index wins
        all_far();
        set_obs(0, 148, 170, 230, 260);
        run_frame("t4_touch", 1'b0, 1'b0);
        set_obs(0, 147, 170, 230, 260);
        run_frame("t4a", 1'b0, 1'b0);
        set_obs(2, 120, 130, 210, 240);
        run_frame("t4b", 1'b0, 1'b0);
        do_reset();

        // 5: negative x and grace
        all_far();
        set_dino(0, 50, 200, 250);
        set_obs(0, -30, -6, 230, 260);
        run_frame("t5_off", 1'b0, 1'b0);
        set_obs(0, -30, 20, 230, 260);
        run_frame("t5a", 1'b0, 1'b0);
        run_frame("t5_grace", 1'b1, 1'b0);
        run_frame("t5b", 1'b0, 1'b0);
        run_frame("t5c", 1'b0, 1'b0);
        do_reset();

        // 6: reset mid-scan, dropped strobes, game-over lockout
        all_far();
        set_dino(100, 150, 200, 250);
        set_obs(1, 140, 170, 230, 260);
        run_frame("t6a", 1'b0, 1'b0);
        reset_mid_scan();
        run_frame("t6_mid", 1'b0, 1'b1);
        strobe_no_animate();
        run_frame("t6b", 1'b0, 1'b0);
        run_frame("t6_go", 1'b0, 1'b0);

        check_eq("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
